// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dual-port dmem request arbiter.
package dmem_pkg;

  localparam int unsigned NCORES_DEF = 4;
  localparam int unsigned ADDRW_DEF  = 14;
  // Tag index is sized for the largest supported core count (8).
  localparam int unsigned TAG_IDXW   = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_IDXW-1:0] idx;
  } tag_t;

  function automatic logic [31:0] word_addr(input logic [31:0] addr, input int unsigned addrw);
    logic [31:0] mask;
    mask = (32'd1 << addrw) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request bus and dmem-side port bus seen by the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned NCORES = 4
);
  logic [NCORES-1:0]    core_req_i;
  logic [NCORES-1:0]    core_we_i;
  logic [32*NCORES-1:0] core_addr_i;
  logic [32*NCORES-1:0] core_wdata_i;
  logic [4*NCORES-1:0]  core_wstrb_i;
  logic [NCORES-1:0]    core_gnt_o;
  logic [NCORES-1:0]    core_rvalid_o;
  logic [32*NCORES-1:0] core_rdata_o;
  logic                 rea_o, reb_o, wea_o, web_o;
  logic [31:0]          addra_o, addrb_o, wdataa_o, wdatab_o;
  logic [3:0]           wstrba_o, wstrbb_o;
  logic [31:0]          rdataa_i, rdatab_i;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_wstrb_i, rdataa_i, rdatab_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, rea_o, reb_o, wea_o, web_o,
    output addra_o, addrb_o, wdataa_o, wdatab_o, wstrba_o, wstrbb_o
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_wstrb_i, rdataa_i, rdatab_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, rea_o, reb_o, wea_o, web_o,
    input  addra_o, addrb_o, wdataa_o, wdatab_o, wstrba_o, wstrbb_o
  );

endinterface

// File: rtl/rr_pick.sv
// Cyclic first-requester picker: scans from start_i and returns a one-hot grant plus index.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  input  logic [N-1:0]         mask_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  logic [$clog2(N)-1:0] w_k;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_k     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_k = $clog2(N)'((32'(start_i) + i) % N);
      if (!valid_o && req_i[w_k] && mask_i[w_k]) begin
        gnt_o[w_k] = 1'b1;
        idx_o      = w_k;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin dmem arbiter with same-word write conflict blocking and read routing.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NCORES = NCORES_DEF,
  parameter int unsigned ADDRW  = ADDRW_DEF
) (
  input logic           clk_i,
  input logic           rst_ni,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NCORES);

  logic [31:0]       w_addr  [NCORES];
  logic [31:0]       w_wdata [NCORES];
  logic [3:0]        w_wstrb [NCORES];
  logic [NCORES-1:0] w_gnt_a, w_gnt_b, w_conflict, w_mask_b;
  logic [IW-1:0]     w_idx_a, w_idx_b, w_start_b, w_last, w_rr_nxt;
  logic              w_vld_a, w_vld_b, w_ga, w_gb, w_we_a, w_we_b;
  logic [IW-1:0]     r_rr;
  tag_t              r_tag_a, r_tag_b;

  for (genvar k = 0; k < NCORES; k++) begin : g_core
    assign w_addr[k]     = bus.core_addr_i[32*k +: 32];
    assign w_wdata[k]    = bus.core_wdata_i[32*k +: 32];
    assign w_wstrb[k]    = bus.core_wstrb_i[4*k +: 4];
    // Any write on the same word as cA excludes that core from port B.
    assign w_conflict[k] = (word_addr(w_addr[k], ADDRW) == word_addr(w_addr[w_idx_a], ADDRW))
                           && (w_we_a || bus.core_we_i[k]);
  end

  rr_pick #(.N(NCORES)) u_pick_a (
    .req_i  (bus.core_req_i),
    .start_i(r_rr),
    .mask_i ({NCORES{1'b1}}),
    .gnt_o  (w_gnt_a),
    .idx_o  (w_idx_a),
    .valid_o(w_vld_a)
  );

  assign w_start_b = (w_idx_a == IW'(NCORES - 1)) ? '0 : w_idx_a + 1'b1;
  assign w_mask_b  = ~w_gnt_a & ~w_conflict;

  rr_pick #(.N(NCORES)) u_pick_b (
    .req_i  (bus.core_req_i),
    .start_i(w_start_b),
    .mask_i (w_mask_b),
    .gnt_o  (w_gnt_b),
    .idx_o  (w_idx_b),
    .valid_o(w_vld_b)
  );

  assign w_ga   = rst_ni && w_vld_a;
  assign w_gb   = w_ga && w_vld_b;
  assign w_we_a = bus.core_we_i[w_idx_a];
  assign w_we_b = bus.core_we_i[w_idx_b];

  assign bus.core_gnt_o = (w_ga ? w_gnt_a : '0) | (w_gb ? w_gnt_b : '0);
  assign bus.rea_o      = w_ga && !w_we_a;
  assign bus.wea_o      = w_ga && w_we_a;
  assign bus.reb_o      = w_gb && !w_we_b;
  assign bus.web_o      = w_gb && w_we_b;
  assign bus.addra_o    = w_ga ? w_addr[w_idx_a] : '0;
  assign bus.addrb_o    = w_gb ? w_addr[w_idx_b] : '0;
  assign bus.wdataa_o   = bus.wea_o ? w_wdata[w_idx_a] : '0;
  assign bus.wdatab_o   = bus.web_o ? w_wdata[w_idx_b] : '0;
  assign bus.wstrba_o   = bus.wea_o ? w_wstrb[w_idx_a] : '0;
  assign bus.wstrbb_o   = bus.web_o ? w_wstrb[w_idx_b] : '0;

  // Port B is always later in scan order than port A, so it is the last grant when present.
  assign w_last   = w_gb ? w_idx_b : w_idx_a;
  assign w_rr_nxt = (w_last == IW'(NCORES - 1)) ? '0 : w_last + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr    <= '0;
      r_tag_a <= '0;
      r_tag_b <= '0;
    end else begin
      if (w_ga) r_rr <= w_rr_nxt;
      r_tag_a.valid <= bus.rea_o;
      r_tag_a.idx   <= TAG_IDXW'(w_idx_a);
      r_tag_b.valid <= bus.reb_o;
      r_tag_b.idx   <= TAG_IDXW'(w_idx_b);
    end
  end

  for (genvar k = 0; k < NCORES; k++) begin : g_resp
    logic w_hit_a, w_hit_b;
    assign w_hit_a = r_tag_a.valid && (r_tag_a.idx == TAG_IDXW'(k));
    assign w_hit_b = r_tag_b.valid && (r_tag_b.idx == TAG_IDXW'(k));
    assign bus.core_rvalid_o[k]         = w_hit_a || w_hit_b;
    assign bus.core_rdata_o[32*k +: 32] = w_hit_a ? bus.rdataa_i :
                                          w_hit_b ? bus.rdatab_i : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dual-port memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [256];

  dmem_arbiter_if #(.NCORES(4)) bus ();

  dmem_arbiter #(.NCORES(4), .ADDRW(14)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rea_o) bus.rdataa_i <= mem[bus.addra_o[9:2]];
    if (bus.reb_o) bus.rdatab_i <= mem[bus.addrb_o[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (bus.wea_o && bus.wstrba_o[b]) mem[bus.addra_o[9:2]][8*b +: 8] = bus.wdataa_o[8*b +: 8];
      if (bus.web_o && bus.wstrbb_o[b]) mem[bus.addrb_o[9:2]][8*b +: 8] = bus.wdatab_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.core_req_i   = '0;
    bus.core_we_i    = '0;
    bus.core_addr_i  = '0;
    bus.core_wdata_i = '0;
    bus.core_wstrb_i = '0;
  endtask

  task automatic req(input logic [1:0] k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.core_req_i[k]             = 1'b1;
    bus.core_we_i[k]              = we;
    bus.core_addr_i[32*k +: 32]   = addr;
    bus.core_wdata_i[32*k +: 32]  = wdata;
    bus.core_wstrb_i[4*k +: 4]    = wstrb;
  endtask

  initial begin
    int cnt [4];
    logic [3:0] exp_g, prev_g;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101_0101;
    mem[4]  = 32'hDEAD_BEEF;
    mem[16] = 32'h4040_4040;
    mem[17] = 32'hCAFE_F00D;
    idle();
    req(2'd1, 1'b0, 32'h10, '0, '0);
    settle();
    chk("rst_gnt", 32'(bus.core_gnt_o), 32'h0);
    chk("rst_rea", 32'(bus.rea_o), 32'h0);
    step();
    step();
    chk("rst_rvalid", 32'(bus.core_rvalid_o), 32'h0);
    chk("rst_rr", 32'(dut.r_rr), 32'h0);

    // 1: single read by core1
    rst_ni = 1'b1;
    settle();
    chk("t1_gnt", 32'(bus.core_gnt_o), 32'h2);
    chk("t1_rea", 32'(bus.rea_o), 32'h1);
    chk("t1_addra", bus.addra_o, 32'h10);
    chk("t1_reb", 32'({bus.reb_o, bus.web_o}), 32'h0);
    step();
    idle();
    chk("t1_rvalid", 32'(bus.core_rvalid_o), 32'h2);
    chk("t1_rdata", bus.core_rdata_o[63:32], 32'hDEAD_BEEF);
    chk("t1_rr", 32'(dut.r_rr), 32'h2);

    // bring pointer back to 0 via a lone core3 grant
    req(2'd3, 1'b0, 32'h0, '0, '0);
    step();
    idle();
    chk("t1b_rr", 32'(dut.r_rr), 32'h0);

    // 2: dual grant, core0 write + core2 read
    req(2'd0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    req(2'd2, 1'b0, 32'h40, '0, '0);
    settle();
    chk("t2_gnt", 32'(bus.core_gnt_o), 32'h5);
    chk("t2_wea", 32'({bus.wea_o, bus.rea_o}), 32'h2);
    chk("t2_addra", bus.addra_o, 32'h20);
    chk("t2_wdataa", bus.wdataa_o, 32'h1122_3344);
    chk("t2_reb", 32'({bus.reb_o, bus.web_o}), 32'h2);
    chk("t2_addrb", bus.addrb_o, 32'h40);
    step();
    idle();
    chk("t2_rvalid", 32'(bus.core_rvalid_o), 32'h4);
    chk("t2_rdata", bus.core_rdata_o[95:64], 32'h4040_4040);
    chk("t2_rr", 32'(dut.r_rr), 32'h3);
    chk("t2_mem", mem[8], 32'h1122_3344);

    // 3: same-word write conflict, core1 waits a cycle then reads the new data
    req(2'd0, 1'b1, 32'h30, 32'hA5A5_5A5A, 4'hF);
    req(2'd1, 1'b0, 32'h30, '0, '0);
    settle();
    chk("t3_gnt0", 32'(bus.core_gnt_o), 32'h1);
    chk("t3_portb0", 32'({bus.reb_o, bus.web_o}), 32'h0);
    step();
    bus.core_req_i[0] = 1'b0;
    bus.core_we_i[0]  = 1'b0;
    settle();
    chk("t3_gnt1", 32'(bus.core_gnt_o), 32'h2);
    chk("t3_rea1", 32'(bus.rea_o), 32'h1);
    step();
    idle();
    chk("t3_rvalid", 32'(bus.core_rvalid_o), 32'h2);
    chk("t3_rdata", bus.core_rdata_o[63:32], 32'hA5A5_5A5A);

    // 4: same-word reads on both ports
    req(2'd2, 1'b0, 32'h44, '0, '0);
    req(2'd3, 1'b0, 32'h44, '0, '0);
    settle();
    chk("t4_gnt", 32'(bus.core_gnt_o), 32'hC);
    chk("t4_en", 32'({bus.rea_o, bus.reb_o}), 32'h3);
    step();
    idle();
    chk("t4_rvalid", 32'(bus.core_rvalid_o), 32'hC);
    chk("t4_rdata2", bus.core_rdata_o[95:64], 32'hCAFE_F00D);
    chk("t4_rdata3", bus.core_rdata_o[127:96], 32'hCAFE_F00D);
    chk("t4_rr", 32'(dut.r_rr), 32'h0);

    // zero-strobe write still grants with we=1 and leaves memory alone
    req(2'd1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0);
    settle();
    chk("ws0_wea", 32'({bus.wea_o, bus.wstrba_o}), 32'h10);
    step();
    idle();
    chk("ws0_rvalid", 32'(bus.core_rvalid_o), 32'h0);
    chk("ws0_mem", mem[4], 32'hDEAD_BEEF);
    req(2'd3, 1'b0, 32'h0, '0, '0);
    step();
    idle();
    chk("t5_rr0", 32'(dut.r_rr), 32'h0);

    // 5: fairness with all four cores reading continuously
    for (int k = 0; k < 4; k++) begin
      req(2'(k), 1'b0, 32'(4 * k), '0, '0);
      cnt[k] = 0;
    end
    settle();
    prev_g = '0;
    for (int c = 0; c < 8; c++) begin
      exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      chk("t5_gnt", 32'(bus.core_gnt_o), 32'(exp_g));
      if (c > 0) chk("t5_rvalid", 32'(bus.core_rvalid_o), 32'(prev_g));
      for (int k = 0; k < 4; k++) cnt[k] += int'(bus.core_gnt_o[k]);
      prev_g = exp_g;
      step();
    end
    idle();
    chk("t5_rvalid_last", 32'(bus.core_rvalid_o), 32'hC);
    for (int k = 0; k < 4; k++) chk("t5_count", 32'(cnt[k]), 32'd4);

    // 6: back-to-back grant then reset before the second read is taken
    req(2'd1, 1'b0, 32'h10, '0, '0);
    step();
    settle();
    chk("t6_gnt_b2b", 32'(bus.core_gnt_o), 32'h2);
    chk("t6_rvalid_b2b", 32'(bus.core_rvalid_o), 32'h2);
    chk("t6_rr_pre", 32'(dut.r_rr), 32'h2);
    rst_ni = 1'b0;
    settle();
    chk("t6_gnt_rst", 32'(bus.core_gnt_o), 32'h0);
    chk("t6_en_rst", 32'({bus.rea_o, bus.reb_o, bus.wea_o, bus.web_o}), 32'h0);
    step();
    chk("t6_rvalid", 32'(bus.core_rvalid_o), 32'h0);
    chk("t6_rr", 32'(dut.r_rr), 32'h0);
    step();
    chk("t6_gnt_hold", 32'(bus.core_gnt_o), 32'h0);
    chk("t6_rvalid_hold", 32'(bus.core_rvalid_o), 32'h0);
    idle();
    rst_ni = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Request arbiter directly upstream of the dual-port data memory in the multicore build.
- Accepts load/store requests from NCORES cores and grants at most two per cycle, one on dmem port A and one on port B.
- Drives the memory's read enables, write enables, byte strobes, addresses and write data.
- Routes the one-cycle-late read data back to the core that issued the load.
- Uses round-robin fairness and blocks same-word write conflicts between the two ports.

Parameters:
- NCORES, 4, number of requesting cores (2..8).
- ADDRW, 14, dmem word-address width; the word index is addr[ADDRW+1:2].

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- core_req_i  in  NCORES  per-core request valid; held stable until granted.
- core_we_i  in  NCORES  per-core write (1) or read (0).
- core_addr_i  in  32*NCORES  per-core byte address; core k uses bits [32k+31:32k].
- core_wdata_i  in  32*NCORES  per-core write data.
- core_wstrb_i  in  4*NCORES  per-core byte strobes.
- core_gnt_o  out  NCORES  request accepted this cycle (combinational).
- core_rvalid_o  out  NCORES  read data valid (registered, one cycle after the read grant).
- core_rdata_o  out  32*NCORES  read data; valid only while that core's rvalid is 1.
- rea_o, reb_o  out  1  dmem port read enables.
- wea_o, web_o  out  1  dmem port write enables.
- addra_o, addrb_o  out  32  dmem port byte addresses.
- wdataa_o, wdatab_o  out  32  dmem port write data.
- wstrba_o, wstrbb_o  out  4  dmem port byte strobes.
- rdataa_i, rdatab_i  in  32  dmem read data; valid the cycle after re* was high.

Behaviour:
- Reset (rst_ni=0 at the clock edge):
  - rr_q=0; both port tags invalid; core_rvalid_o=0.
  - While rst_ni=0, core_gnt_o=0 and re*/we*=0 (combinational gating).
  - Address, data and strobe outputs: don't care when their enables are 0; drive 0.
- Grant selection (combinational):
  - Scan cores cyclically starting at rr_q.
  - The first requester found, cA, gets port A.
  - Continue the scan after cA; the next requester cB that does not conflict gets port B.
  - Conflict: word addr(cA) == word addr(cB) and (we[cA] or we[cB]). A conflicting cB is skipped; the scan continues to later requesters.
  - Two reads of the same word are allowed on both ports.
  - Zero requesters: no enables asserted.
  - One requester: port A only; port B idle.
- Port drive:
  - Granted read: re=1, we=0.
  - Granted write: we=1, re=0, strobe and data passed through unchanged.
  - A write with wstrb=0 is still granted, with we=1; memory content is unchanged.
- Pointer update: rr_q <= (last granted core + 1) mod NCORES; rr_q holds if nothing was granted.
- Response path:
  - Each port has a registered tag {valid, core index}, set from that port's read grant.
  - In the next cycle, core_rvalid_o[tag] = 1 and core_rdata_o[tag] = rdata of that port.
  - Writes produce no rvalid.
  - Both ports may return to different cores in the same cycle.
- Back-to-back: a core may be re-granted the cycle after its own grant. Its rvalid for the earlier read then coincides with the new grant.
- Reset mid-operation: outstanding tags are cleared. An rvalid due in the cycle after reset is suppressed.
- Ordering:
  - Within one core, requests are serialized by the handshake.
  - Across ports in the same cycle, no same-word write conflict can be issued, so dmem never sees a dual-port write race.

Decomposition:
- Package dmem_pkg holds:
  - NCORES_DEF and ADDRW_DEF;
  - the tag struct {valid, idx[$clog2(NCORES)-1:0]};
  - a function word_addr(addr) returning addr[ADDRW+1:2].
- One sub-module is natural: rr_pick. It takes a request vector, a start pointer and a mask, and returns a one-hot grant plus its index. It is instantiated twice:
  - port A, with an all-ones mask;
  - port B, with the request vector masked by the cA one-hot and by the conflict vector, starting at cA+1.

Test Plan:
1. Reset and single read:
   - Hold rst_ni=0 for 2 cycles, then release.
   - Core1 reads 0x0000_0010, with preloaded word 4 = 0xDEADBEEF.
   - Required: gnt[1]=1 and rea_o=1 in cycle 0; core_rvalid_o[1]=1 with rdata 0xDEADBEEF in cycle 1; nothing on port B.
2. Dual grant:
   - With rr_q=0, core0 writes 0x20 (wdata 0x11223344, wstrb 0xF) and core2 reads 0x40, both in the same cycle.
   - Required: wea_o=1 with addra_o=0x20, reb_o=1 with addrb_o=0x40, gnt=4'b0101; core_rvalid_o[2] next cycle; rr_q=3.
3. Write conflict:
   - Core0 writes 0x30 and core1 reads 0x30 (same word) with rr_q=0.
   - Required: only core0 granted, on port A; core1 granted the next cycle on port A and reads back the written data.
4. Same-word reads: cores 2 and 3 both read 0x44 -> both granted in one cycle; both rvalid next cycle with identical data.
5. Fairness:
   - All 4 cores read continuously for 8 cycles.
   - Required: grant pairs (0,1), (2,3), (0,1), ...; every core gets 4 grants, and no core waits more than 2 cycles.
6. Reset mid-read: core1 is granted a read, then rst_ni=0 on the next edge -> core_rvalid_o stays 0, rr_q=0, no grants while reset is held.
